mem_bus_arbiter: RTL

Shares a single memory port between the instruction-fetch bus and the data bus. It sits between the fetch/memory stages and the memory interface. Each request is latched at grant and driven onto the memory port. The read data is returned to the winning requester as a one-cycle response pulse. One transaction is in flight at a time; the data bus wins by default, with optional anti-starvation for fetch.

---
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle for mem_bus_arbiter: fetch bus, data bus and the shared memory port.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface mem_bus_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_data;

  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [63:0] d_rdata;

  logic        m_valid;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [63:0] m_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_addr_ok, i_data_ok, i_data,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_valid, m_addr, m_size, m_strobe, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_addr_ok, i_data_ok, i_data,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_valid, m_addr, m_size, m_strobe, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (ibus) and data (dbus); one transaction in flight.
// Define ARB_FAIR_EN to let a waiting fetch win after STARVE_LIMIT consecutive dbus grants.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner;      // 1 = dbus owns the port
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        req_any;
  logic        grant_d;
  logic        take_rdata;
  logic        m_valid_c;
  logic        d_ok_c;
  logic        i_ok_c;

  assign req_any    = bus.i_valid | bus.d_valid;
  assign take_rdata = bus.m_data_ok &&
                      ((state == DATA) || (state == ADDR && bus.m_addr_ok));

`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve;

  assign grant_d = bus.d_valid && !(bus.i_valid && starve == CW'(STARVE_LIMIT));

  // Counts dbus grants that left a fetch waiting; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if (bus.i_valid && bus.d_valid && grant_d) starve <= starve + 1'b1;
      else                                       starve <= '0;
    end
  end
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;

  assign grant_d = bus.d_valid;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: each combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ADDR;
      ADDR:    if (bus.m_addr_ok) state_nxt = bus.m_data_ok ? RESP : DATA;
      DATA:    if (bus.m_data_ok) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A fetch response is only delivered if the fetcher still wants that exact address.
  always_comb begin
    m_valid_c = 1'b0;
    d_ok_c    = 1'b0;
    i_ok_c    = 1'b0;
    case (state)
      ADDR: m_valid_c = 1'b1;
      RESP: begin
        if (owner) d_ok_c = 1'b1;
        else       i_ok_c = bus.i_valid && (bus.i_addr == addr_q);
      end
      default: ;
    endcase
  end

  // NOTE: the request/response registers are reset too, because they drive outputs
  // that must read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        owner <= grant_d;
        if (grant_d) begin
          addr_q   <= bus.d_addr;
          size_q   <= bus.d_size;
          strobe_q <= bus.d_strobe;
          wdata_q  <= bus.d_wdata;
        end else begin
          addr_q   <= bus.i_addr;
          size_q   <= 3'b010;
          strobe_q <= '0;
          wdata_q  <= '0;
        end
      end
      if (take_rdata) rdata_q <= bus.m_rdata;
    end
  end

  assign bus.m_valid   = m_valid_c;
  assign bus.m_addr    = addr_q;
  assign bus.m_size    = size_q;
  assign bus.m_strobe  = strobe_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.d_addr_ok = d_ok_c;
  assign bus.d_data_ok = d_ok_c;
  assign bus.d_rdata   = rdata_q;
  assign bus.i_addr_ok = i_ok_c;
  assign bus.i_data_ok = i_ok_c;
  assign bus.i_data    = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];

endmodule
